// File: rtl/dtpu_in_stager.sv
// Ping-pong input stager: fetches up to ROWS FIFO words per command into one of two banks for the MXU.
// Optional DTPU_STG_STALL_CNT_EN adds a saturating count of FETCH cycles stalled on an empty FIFO.
module dtpu_in_stager #(
   parameter int DATA_WIDTH_FIFO_IN = 64,
   parameter int ROWS               = 8,
   parameter int LEN_WIDTH          = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [LEN_WIDTH-1:0]               cmd_len,
   input  logic                               cmd_bcast,
   input  logic [3:0]                         cmd_prec,
   input  logic                               infifo_is_empty,
   input  logic [DATA_WIDTH_FIFO_IN-1:0]      infifo_dout,
   output logic                               infifo_read,
   output logic                               stg_valid,
   input  logic                               stg_ready,
   output logic [ROWS*DATA_WIDTH_FIFO_IN-1:0] stg_data,
   output logic [3:0]                         stg_prec,
   output logic                               busy
`ifdef DTPU_STG_STALL_CNT_EN
   ,
   output logic [31:0]                        stall_cnt
`endif
);

   localparam int W  = DATA_WIDTH_FIFO_IN;
   localparam int RW = $clog2(ROWS);
   localparam logic [LEN_WIDTH-1:0] ROWS_L = LEN_WIDTH'(ROWS);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t               state_q;
   logic                 fill_ptr_q;
   logic                 rd_ptr_q;
   logic [1:0]           full_q;
   logic [3:0]           prec_q [2];
   logic [W-1:0]         bank_q [2][ROWS];
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] issued_q;
   logic [LEN_WIDTH-1:0] capt_q;
   logic                 bcast_q;
   logic                 pend_q;
   logic [3:0]           cmd_prec_q;
   logic [LEN_WIDTH-1:0] len_d;
   logic                 accept;
   logic                 consume;

   always_comb begin
      len_d = (cmd_len > ROWS_L) ? ROWS_L : cmd_len;
      if (cmd_bcast) len_d = LEN_WIDTH'(1);
   end

   assign cmd_ready   = !reset && (state_q == IDLE) && !full_q[fill_ptr_q];
   assign accept      = cmd_valid && cmd_ready;
   assign infifo_read = (state_q == FETCH) && !infifo_is_empty && (issued_q < len_q);
   assign stg_valid   = full_q[rd_ptr_q];
   assign consume     = stg_valid && stg_ready;
   assign stg_prec    = prec_q[rd_ptr_q];
   assign busy        = (state_q != IDLE) || (|full_q);

   always_comb begin
      stg_data = '0;
      for (int r = 0; r < ROWS; r++) stg_data[r*W +: W] = bank_q[rd_ptr_q][r];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fill_ptr_q <= 1'b0;
         rd_ptr_q   <= 1'b0;
         full_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         capt_q     <= '0;
         bcast_q    <= 1'b0;
         pend_q     <= 1'b0;
         cmd_prec_q <= '0;
         for (int b = 0; b < 2; b++) begin
            prec_q[b] <= '0;
            for (int r = 0; r < ROWS; r++) bank_q[b][r] <= '0;
         end
      end else begin
         // Word popped last cycle is on infifo_dout now.
         if (pend_q) begin
            if (bcast_q) begin
               for (int r = 0; r < ROWS; r++) bank_q[fill_ptr_q][r] <= infifo_dout;
            end else begin
               bank_q[fill_ptr_q][capt_q[RW-1:0]] <= infifo_dout;
            end
            capt_q <= capt_q + LEN_WIDTH'(1);
         end
         pend_q <= infifo_read;

         if (consume) begin
            full_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q         <= ~rd_ptr_q;
         end

         case (state_q)
            IDLE: begin
               if (accept) begin
                  len_q      <= len_d;
                  bcast_q    <= cmd_bcast;
                  cmd_prec_q <= cmd_prec;
                  issued_q   <= '0;
                  capt_q     <= '0;
                  for (int r = 0; r < ROWS; r++) bank_q[fill_ptr_q][r] <= '0;
                  state_q    <= (len_d == '0) ? DRAIN : FETCH;
               end
            end
            FETCH: begin
               if (infifo_read) begin
                  issued_q <= issued_q + LEN_WIDTH'(1);
                  if ((issued_q + LEN_WIDTH'(1)) == len_q) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               full_q[fill_ptr_q] <= 1'b1;
               prec_q[fill_ptr_q] <= cmd_prec_q;
               fill_ptr_q         <= ~fill_ptr_q;
               state_q            <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DTPU_STG_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if ((state_q == FETCH) && infifo_is_empty && (issued_q < len_q)
                   && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dtpu_in_stager.sv
// Directed bench for dtpu_in_stager: fetch, partial/clamp, zero length, broadcast, ping-pong, stall, reset.
module tb_dtpu_in_stager;
   localparam int W    = 64;
   localparam int ROWS = 8;
   localparam int LW   = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [LW-1:0]        cmd_len;
   logic                 cmd_bcast;
   logic [3:0]           cmd_prec;
   logic                 infifo_is_empty;
   logic [W-1:0]         infifo_dout;
   logic                 infifo_read;
   logic                 stg_valid;
   logic                 stg_ready;
   logic [ROWS*W-1:0]    stg_data;
   logic [3:0]           stg_prec;
   logic                 busy;
`ifdef DTPU_STG_STALL_CNT_EN
   logic [31:0]          stall_cnt;
`endif

   dtpu_in_stager #(.DATA_WIDTH_FIFO_IN(W), .ROWS(ROWS), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_bcast(cmd_bcast), .cmd_prec(cmd_prec),
      .infifo_is_empty(infifo_is_empty), .infifo_dout(infifo_dout), .infifo_read(infifo_read),
      .stg_valid(stg_valid), .stg_ready(stg_ready), .stg_data(stg_data),
      .stg_prec(stg_prec), .busy(busy)
`ifdef DTPU_STG_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // FIFO model with one-cycle read latency
   logic [W-1:0] fifo_mem [128];
   int           fifo_n = 0;
   int           rd_idx = 0;
   logic         fifo_flush = 1'b0;
   int           pop_cnt = 0;
   int           rd_while_empty = 0;

   assign infifo_is_empty = (rd_idx >= fifo_n);

   always @(posedge clk) begin
      if (infifo_read) begin
         pop_cnt <= pop_cnt + 1;
         if (infifo_is_empty) rd_while_empty <= rd_while_empty + 1;
      end
      if (fifo_flush) begin
         rd_idx <= fifo_n;
      end else if (infifo_read && !infifo_is_empty) begin
         infifo_dout <= fifo_mem[rd_idx];
         rd_idx      <= rd_idx + 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int pop_base = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rep(input logic [7:0] b);
      return {8{b}};
   endfunction

   function automatic logic [63:0] row(input int r);
      return stg_data[r*W +: W];
   endfunction

   task automatic load(input logic [63:0] w);
      fifo_mem[fifo_n] = w;
      fifo_n++;
   endtask

   task automatic flush();
      fifo_flush = 1'b1;
      @(negedge clk);
      fifo_flush = 1'b0;
   endtask

   // Returns at the negedge of the first cycle after the accept edge.
   task automatic accept_cmd(input logic [3:0] len, input logic bc, input logic [3:0] pr);
      int n;
      n = 0;
      pop_base  = pop_cnt;
      cmd_valid = 1'b1;
      cmd_len   = len;
      cmd_bcast = bc;
      cmd_prec  = pr;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept_wait", 64'(n < 50), 64'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(input int start, output int lat);
      lat = start;
      while (!stg_valid && lat < 80) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic consume();
      stg_ready = 1'b1;
      @(negedge clk);
      stg_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int p6;
      reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_bcast = 1'b0; cmd_prec = '0; stg_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("rst_stg_valid", 64'(stg_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_infifo_read", 64'(infifo_read), 64'd0);
      check("rst_stg_data_zero", 64'(stg_data == '0), 64'd1);
      check("rst_stg_prec", 64'(stg_prec), 64'd0);
`ifdef DTPU_STG_STALL_CNT_EN
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      reset = 1'b0;
      @(negedge clk);
      check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

      // Basic full tile
      for (int i = 0; i < 8; i++) load(rep(8'(i + 1)));
      accept_cmd(4'd8, 1'b0, 4'd1);
      wait_valid(1, lat);
      check("t1_latency", 64'(lat), 64'd10);
      check("t1_pops", 64'(pop_cnt - pop_base), 64'd8);
      for (int r = 0; r < ROWS; r++) check($sformatf("t1_row%0d", r), row(r), rep(8'(r + 1)));
      check("t1_prec", 64'(stg_prec), 64'd1);
      check("t1_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("t1_hold_valid", 64'(stg_valid), 64'd1);
      check("t1_hold_row3", row(3), rep(8'd4));
      consume();
      check("t1_consumed", 64'(stg_valid), 64'd0);

      // Partial tile
      for (int i = 0; i < 4; i++) load(rep(8'((i + 1) * 17)));
      accept_cmd(4'd3, 1'b0, 4'd2);
      wait_valid(1, lat);
      check("t2_latency", 64'(lat), 64'd5);
      check("t2_pops", 64'(pop_cnt - pop_base), 64'd3);
      for (int r = 0; r < ROWS; r++)
         check($sformatf("t2_row%0d", r), row(r), (r < 3) ? rep(8'((r + 1) * 17)) : 64'd0);
      check("t2_prec", 64'(stg_prec), 64'd2);
      consume();
      flush();

      // Length clamp
      for (int i = 0; i < 10; i++) load(rep(8'(160 + i)));
      accept_cmd(4'd12, 1'b0, 4'd4);
      wait_valid(1, lat);
      check("t3_latency", 64'(lat), 64'd10);
      check("t3_pops", 64'(pop_cnt - pop_base), 64'd8);
      for (int r = 0; r < ROWS; r++) check($sformatf("t3_row%0d", r), row(r), rep(8'(160 + r)));
      consume();
      flush();

      // Zero length into a bank holding stale data
      accept_cmd(4'd0, 1'b0, 4'd8);
      wait_valid(1, lat);
      check("t4_latency", 64'(lat), 64'd2);
      check("t4_pops", 64'(pop_cnt - pop_base), 64'd0);
      check("t4_all_zero", 64'(stg_data == '0), 64'd1);
      check("t4_prec", 64'(stg_prec), 64'd8);
      consume();

      // Broadcast
      load(64'hCAFE_CAFE_CAFE_CAFE);
      load(64'hDEAD_DEAD_DEAD_DEAD);
      accept_cmd(4'd5, 1'b1, 4'd2);
      wait_valid(1, lat);
      check("t5_latency", 64'(lat), 64'd3);
      check("t5_pops", 64'(pop_cnt - pop_base), 64'd1);
      for (int r = 0; r < ROWS; r++) check($sformatf("t5_row%0d", r), row(r), 64'hCAFE_CAFE_CAFE_CAFE);
      consume();
      flush();

      // Ping-pong backpressure
      p6 = pop_cnt;
      load(rep(8'hA1)); load(rep(8'hA2)); load(rep(8'hB1));
      load(rep(8'hB2)); load(rep(8'hC1)); load(rep(8'hC2));
      accept_cmd(4'd2, 1'b0, 4'd1);
      wait_valid(1, lat);
      check("t6_a_latency", 64'(lat), 64'd4);
      accept_cmd(4'd2, 1'b0, 4'd2);
      repeat (5) @(negedge clk);
      cmd_valid = 1'b1; cmd_len = 4'd2; cmd_bcast = 1'b0; cmd_prec = 4'd4;
      repeat (3) @(negedge clk);
      check("t6_full_cmd_ready", 64'(cmd_ready), 64'd0);
      check("t6_full_infifo_read", 64'(infifo_read), 64'd0);
      check("t6_full_pops", 64'(pop_cnt - p6), 64'd4);
      check("t6_head_a", row(0), rep(8'hA1));
      stg_ready = 1'b1;
      check("t6_ready_not_comb", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      stg_ready = 1'b0;
      check("t6_freed_cmd_ready", 64'(cmd_ready), 64'd1);
      check("t6_head_b_valid", 64'(stg_valid), 64'd1);
      check("t6_head_b_row0", row(0), rep(8'hB1));
      check("t6_head_b_prec", 64'(stg_prec), 64'd2);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_hold_b_row1", row(1), rep(8'hB2));
      check("t6_both_full_cmd_ready", 64'(cmd_ready), 64'd0);
      check("t6_total_pops", 64'(pop_cnt - p6), 64'd6);
      consume();
      check("t6_c_valid", 64'(stg_valid), 64'd1);
      check("t6_c_row0", row(0), rep(8'hC1));
      check("t6_c_row1", row(1), rep(8'hC2));
      check("t6_c_row2", row(2), 64'd0);
      check("t6_c_prec", 64'(stg_prec), 64'd4);
      consume();
      check("t6_drained_valid", 64'(stg_valid), 64'd0);
      check("t6_drained_busy", 64'(busy), 64'd0);

      // Empty stall mid-tile: cycles 4..8 see an empty FIFO
      for (int i = 0; i < 3; i++) load(rep(8'(8'h71 + i)));
      accept_cmd(4'd8, 1'b0, 4'd1);
      repeat (5) @(negedge clk);
      check("t7_stall_no_read", 64'(infifo_read), 64'd0);
      check("t7_stall_busy", 64'(busy), 64'd1);
      check("t7_stall_pops", 64'(pop_cnt - pop_base), 64'd3);
      repeat (3) @(negedge clk);
      for (int i = 3; i < 8; i++) load(rep(8'(8'h71 + i)));
      wait_valid(9, lat);
      check("t7_latency", 64'(lat), 64'd15);
      check("t7_pops", 64'(pop_cnt - pop_base), 64'd8);
      for (int r = 0; r < ROWS; r++) check($sformatf("t7_row%0d", r), row(r), rep(8'(8'h71 + r)));
`ifdef DTPU_STG_STALL_CNT_EN
      check("t7_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
      consume();

      // Reset after four pops
      for (int i = 0; i < 8; i++) load(rep(8'(8'h81 + i)));
      accept_cmd(4'd8, 1'b0, 4'd2);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t8_rst_pops", 64'(pop_cnt - pop_base), 64'd4);
      check("t8_rst_stg_valid", 64'(stg_valid), 64'd0);
      check("t8_rst_infifo_read", 64'(infifo_read), 64'd0);
      check("t8_rst_busy", 64'(busy), 64'd0);
      check("t8_rst_cmd_ready", 64'(cmd_ready), 64'd0);
      check("t8_rst_row0", row(0), 64'd0);
`ifdef DTPU_STG_STALL_CNT_EN
      check("t8_rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      reset = 1'b0;
      flush();
      for (int i = 0; i < 8; i++) load(rep(8'(8'h91 + i)));
      accept_cmd(4'd8, 1'b0, 4'd4);
      wait_valid(1, lat);
      check("t8_latency", 64'(lat), 64'd10);
      check("t8_pops", 64'(pop_cnt - pop_base), 64'd8);
      for (int r = 0; r < ROWS; r++) check($sformatf("t8_row%0d", r), row(r), rep(8'(8'h91 + r)));
      check("t8_prec", 64'(stg_prec), 64'd4);
      consume();

      check("read_while_empty", 64'(rd_while_empty), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
